// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : gmii_tx_framer
// Description : GMII transmit framer. Wraps a payload byte stream with
//               preamble, SFD, zero pad up to the minimum frame size and the
//               FCS supplied by an external byte-wide CRC-32 stage, then
//               enforces the inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,   // 0x55 bytes ahead of the SFD (>= 2)
    parameter int MIN_PAYLOAD  = 60,  // payload + pad bytes before the FCS
    parameter int IFG_LEN      = 12   // idle cycles after the last FCS byte (>= 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  crc_data,
    output logic        crc_en,
    output logic        crc_init,
    input  logic [31:0] crc_out,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        tx_underrun
);

    localparam logic [7:0]         c_PRE_BYTE   = 8'h55;
    localparam logic [7:0]         c_SFD_BYTE   = 8'hD5;
    localparam int                 c_CNT_W      = 8;
    // The IDLE state already emits the first preamble byte, so PRE covers
    // PREAMBLE_LEN-1 cycles; the counter runs down to zero inclusive.
    localparam logic [c_CNT_W-1:0] c_PRE_RELOAD = c_CNT_W'(PREAMBLE_LEN - 2);
    localparam logic [c_CNT_W-1:0] c_IFG_RELOAD = c_CNT_W'(IFG_LEN - 1);
    localparam logic [11:0]        c_MIN_LEN    = 12'(MIN_PAYLOAD);
    localparam logic [10:0]        c_CNT_MAX    = 11'd2047;

    // Each state names the byte loaded into gmii_txd at the next edge.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_DATA = 3'd3,
        S_PAD  = 3'd4,
        S_FCS  = 3'd5,
        S_IFG  = 3'd6
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;        // preamble / IFG down-counter
    logic [10:0]        r_byte_cnt;   // payload + pad bytes sent so far
    logic [1:0]         r_fcs_idx;    // which FCS byte goes out next
    logic [7:0]         r_txd;
    logic               r_tx_en;
    logic               r_tx_er;
    logic               r_underrun;

    logic               w_accept;
    logic [11:0]        w_next_len;
    logic [10:0]        w_byte_cnt_inc;
    logic [7:0]         w_fcs_byte;

    assign w_accept       = (r_state == S_DATA) && tx_valid;
    assign w_next_len     = {1'b0, r_byte_cnt} + 12'd1;
    assign w_byte_cnt_inc = (r_byte_cnt == c_CNT_MAX) ? r_byte_cnt : r_byte_cnt + 11'd1;

    // FCS goes out least-significant byte first
    always_comb begin
        w_fcs_byte = crc_out[7:0];
        case (r_fcs_idx)
            2'd0:    w_fcs_byte = crc_out[7:0];
            2'd1:    w_fcs_byte = crc_out[15:8];
            2'd2:    w_fcs_byte = crc_out[23:16];
            default: w_fcs_byte = crc_out[31:24];
        endcase
    end

    // The CRC stage sees exactly the byte entering gmii_txd on the same edge,
    // so its result already covers the last payload/pad byte when FCS starts.
    assign tx_ready = (r_state == S_DATA);
    assign crc_init = (r_state == S_PRE);
    assign crc_en   = !crc_init && (w_accept || (r_state == S_PAD));
    assign crc_data = w_accept ? tx_data : 8'h00;

    assign gmii_txd    = r_txd;
    assign gmii_tx_en  = r_tx_en;
    assign gmii_tx_er  = r_tx_er;
    assign tx_underrun = r_underrun;
    assign busy        = (r_state != S_IDLE);

    // Framing state machine with registered GMII outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_fcs_idx  <= '0;
            r_txd      <= '0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_tx_er    <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_txd      <= 8'h00;
                    r_tx_en    <= 1'b0;
                    r_byte_cnt <= '0;
                    r_fcs_idx  <= '0;
                    if (tx_valid) begin
                        r_txd   <= c_PRE_BYTE;
                        r_tx_en <= 1'b1;
                        r_cnt   <= c_PRE_RELOAD;
                        r_state <= S_PRE;
                    end
                end
                S_PRE: begin
                    r_txd   <= c_PRE_BYTE;
                    r_tx_en <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= S_SFD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SFD: begin
                    r_txd   <= c_SFD_BYTE;
                    r_tx_en <= 1'b1;
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    r_tx_en <= 1'b1;
                    if (tx_valid) begin
                        r_txd      <= tx_data;
                        r_byte_cnt <= w_byte_cnt_inc;
                        if (tx_last) begin
                            r_state <= (w_next_len < c_MIN_LEN) ? S_PAD : S_FCS;
                        end
                    end else begin
                        // Source starved mid-frame: poison the frame and skip the FCS
                        r_txd      <= 8'h00;
                        r_tx_er    <= 1'b1;
                        r_underrun <= 1'b1;
                        r_cnt      <= c_IFG_RELOAD;
                        r_state    <= S_IFG;
                    end
                end
                S_PAD: begin
                    r_txd      <= 8'h00;
                    r_tx_en    <= 1'b1;
                    r_byte_cnt <= w_byte_cnt_inc;
                    if (w_next_len >= c_MIN_LEN) begin
                        r_state <= S_FCS;
                    end
                end
                S_FCS: begin
                    r_txd     <= w_fcs_byte;
                    r_tx_en   <= 1'b1;
                    r_fcs_idx <= r_fcs_idx + 2'd1;
                    if (r_fcs_idx == 2'd3) begin
                        r_cnt   <= c_IFG_RELOAD;
                        r_state <= S_IFG;
                    end
                end
                S_IFG: begin
                    r_txd   <= 8'h00;
                    r_tx_en <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_txd   <= 8'h00;
                    r_tx_en <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gmii_tx_framer
// Description : Self-checking bench for gmii_tx_framer. A byte-wise CRC-32
//               stage closes the loop; frames seen on GMII are compared with
//               frames built from the framing rules by a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;

    localparam int c_PRE = 7;
    localparam int c_MIN = 60;
    localparam int c_IFG = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [7:0]  crc_data;
    logic        crc_en;
    logic        crc_init;
    logic [31:0] crc_out;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        tx_underrun;

    gmii_tx_framer #(
        .PREAMBLE_LEN (c_PRE),
        .MIN_PAYLOAD  (c_MIN),
        .IFG_LEN      (c_IFG)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .crc_data    (crc_data),
        .crc_en      (crc_en),
        .crc_init    (crc_init),
        .crc_out     (crc_out),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    always #4 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- byte-wide CRC-32 stage (reflected, preset all-ones)
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [31:0] crc_r = 32'hFFFFFFFF;
    always @(posedge clk) begin
        if (crc_init)    crc_r <= 32'hFFFFFFFF;
        else if (crc_en) crc_r <= crc_step(crc_r, crc_data);
    end
    assign crc_out = ~crc_r;

    // ---------------- reference model: CRC-32 over a whole message, bit serial
    function automatic logic [31:0] crc32_ref(input logic [7:0] msg[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (msg[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ msg[k][i];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    typedef struct {
        int          len;
        int          ready;
        bit          abort;
        bit          b2b;
        logic [31:0] fcs;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] pay[$];
    bit         prev_keep = 1'b0;

    // ---------------- GMII monitor, sampled on the falling edge
    int         cyc = 0;
    bit         prev_en = 1'b0;
    int         last_l = -1;
    int         busy_chk1 = -1;
    int         busy_chk2 = -1;
    logic [7:0] cap[$];
    int         er_cnt, under_cnt, ready_cnt;
    logic       last_er;
    int         ready_idle = 0;
    int         idle_bad = 0;

    always @(negedge clk) begin
        exp_t       e;
        int         bad, sz;
        logic [7:0] ex;
        cyc++;
        if (!rst_n) begin
            prev_en   = 1'b0;
            last_l    = -1;
            busy_chk1 = -1;
            busy_chk2 = -1;
            cap.delete();
        end else begin
            if (cyc == busy_chk1) chk("busy_in_ifg", busy, 1'b1);
            if (cyc == busy_chk2) chk("busy_back_idle", busy, 1'b0);
            if (gmii_tx_en) begin
                if (!prev_en) begin
                    if (last_l >= 0) begin
                        if (exp_q.size() > 0 && exp_q[0].b2b) chk("b2b_gap", cyc - last_l - 1, c_IFG);
                        else chk("gap_min", (cyc - last_l - 1) >= c_IFG, 1);
                    end
                    cap.delete();
                    er_cnt = 0; under_cnt = 0; ready_cnt = 0; last_er = 1'b0;
                end
                cap.push_back(gmii_txd);
                last_er = gmii_tx_er;
                if (gmii_tx_er)  er_cnt++;
                if (tx_underrun) under_cnt++;
                if (tx_ready)    ready_cnt++;
            end else begin
                if (tx_ready) ready_idle++;
                if (gmii_txd != 8'h00 || gmii_tx_er || tx_underrun) idle_bad++;
                if (prev_en) begin
                    last_l    = cyc - 1;
                    busy_chk1 = cyc;
                    busy_chk2 = cyc + c_IFG - 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame_len", cap.size(), 0);
                    end else begin
                        e  = exp_q.pop_front();
                        sz = cap.size();
                        chk("frame_len", sz, e.len);
                        bad = 0;
                        for (int k = 0; k < e.len; k++) begin
                            ex = exp_bytes.pop_front();
                            if (k >= sz || cap[k] !== ex) bad++;
                        end
                        chk("byte_mismatches", bad, 0);
                        if (!e.abort && sz >= 4)
                            chk("fcs", {cap[sz-1], cap[sz-2], cap[sz-3], cap[sz-4]}, e.fcs);
                        chk("er_count", er_cnt, {31'd0, e.abort});
                        chk("er_on_last", {31'd0, last_er}, {31'd0, e.abort});
                        chk("underrun_pulses", under_cnt, {31'd0, e.abort});
                        chk("ready_cycles", ready_cnt, e.ready);
                    end
                end
            end
            prev_en = gmii_tx_en;
        end
    end

    // ---------------- driver; mode 0 normal, 1 underrun after stop bytes,
    //                  2 reset after stop bytes. Called at a falling edge.
    task automatic send_frame(input int mode, input int stop, input bit keep);
        exp_t       e;
        logic [7:0] padded[$];
        int         n, i, wait_cyc;
        bit         hs;
        n = pay.size();
        if (mode == 0) begin
            padded = pay;
            while (padded.size() < c_MIN) padded.push_back(8'h00);
            e.fcs   = crc32_ref(padded);
            e.len   = c_PRE + 1 + padded.size() + 4;
            e.ready = n;
            e.abort = 1'b0;
            e.b2b   = prev_keep;
            repeat (c_PRE) exp_bytes.push_back(8'h55);
            exp_bytes.push_back(8'hD5);
            foreach (padded[k]) exp_bytes.push_back(padded[k]);
            for (int k = 0; k < 4; k++) exp_bytes.push_back(e.fcs[8*k +: 8]);
            exp_q.push_back(e);
        end else if (mode == 1) begin
            e.fcs   = 32'h0;
            e.len   = c_PRE + 1 + stop + 1;
            e.ready = stop + 1;
            e.abort = 1'b1;
            e.b2b   = prev_keep;
            repeat (c_PRE) exp_bytes.push_back(8'h55);
            exp_bytes.push_back(8'hD5);
            for (int k = 0; k < stop; k++) exp_bytes.push_back(pay[k]);
            exp_bytes.push_back(8'h00);
            exp_q.push_back(e);
        end
        prev_keep = keep;
        i = 0; wait_cyc = 0;
        tx_valid = 1'b1;
        tx_data  = pay[0];
        tx_last  = (n == 1);
        while (i < n) begin
            hs = tx_ready;
            @(posedge clk);
            @(negedge clk);
            if (hs) begin
                i++;
                wait_cyc = 0;
                if (mode != 0 && i == stop) break;
                if (i < n) begin
                    tx_data = pay[i];
                    tx_last = (i == n - 1);
                end
            end else begin
                wait_cyc++;
                if (wait_cyc > 200) begin
                    chk("driver_timeout", wait_cyc, 0);
                    break;
                end
            end
        end
        if (mode == 1) begin
            tx_valid = 1'b0;
            tx_last  = 1'b1;   // last without valid must not rescue the frame
            tx_data  = 8'($urandom);
        end else if (mode == 2) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rst_mid_tx_en", gmii_tx_en, 1'b0);
            chk("rst_mid_tx_er", gmii_tx_er, 1'b0);
            chk("rst_mid_txd", gmii_txd, 8'h00);
            chk("rst_mid_busy", busy, 1'b0);
            chk("rst_mid_ready", tx_ready, 1'b0);
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end else if (!keep) begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
        end
    endtask

    task automatic fill_rand(input int n);
        pay.delete();
        for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx_en", gmii_tx_en, 1'b0);
        chk("reset_tx_er", gmii_tx_er, 1'b0);
        chk("reset_txd", gmii_txd, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_underrun", tx_underrun, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // "123456789" padded to the minimum size
        pay.delete();
        for (int k = 0; k < 9; k++) pay.push_back(8'(8'h31 + k));
        send_frame(0, 0, 1'b0);
        repeat (4) @(negedge clk);
        // single byte, maximal padding
        pay.delete(); pay.push_back(8'hAB);
        send_frame(0, 0, 1'b0);
        // exactly minimum and one above: no pad
        fill_rand(60); send_frame(0, 0, 1'b0);
        repeat (20) @(negedge clk);
        fill_rand(61); send_frame(0, 0, 1'b0);
        // back-to-back with tx_valid held high, second frame padded
        fill_rand(70); send_frame(0, 0, 1'b1);
        fill_rand(30); send_frame(0, 0, 1'b0);
        repeat (2) @(negedge clk);
        // underrun after byte 20
        fill_rand(40); send_frame(1, 20, 1'b0);
        repeat (30) @(negedge clk);
        // reset mid-DATA, then a clean frame
        fill_rand(40); send_frame(2, 10, 1'b0);
        repeat (2) @(negedge clk);
        fill_rand(64); send_frame(0, 0, 1'b0);
        // random mix
        for (int f = 0; f < 8; f++) begin
            fill_rand($urandom_range(1, 130));
            send_frame(0, 0, (f == 7) ? 1'b0 : 1'($urandom_range(0, 1)));
            if (!prev_keep) repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("frames_pending", exp_q.size(), 0);
        repeat (c_IFG + 4) @(negedge clk);
        chk("ready_outside_frame", ready_idle, 0);
        chk("idle_line_activity", idle_bad, 0);
        chk("final_busy", busy, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
